// File: rtl/mem_log_reader.sv
// mem_log_reader
//   Dump engine for the dual-BRAM sample logger. When a start pulse arrives
//   while the logger reports full, it walks every log address, fetches each
//   2*BRAM_DATA_WIDTH-bit word and streams it out LSB byte first over a
//   valid/ready byte interface toward the UART TX path.
//
//   Build option: define MEM_LOG_READER_HEADER_EN to prepend a two-byte
//   header (0xA5, 0x5A) to every dump.
//
// Ports
//   clk                  rising-edge clock
//   i_rst                synchronous active-high reset
//   i_start_read         1-cycle request for a full dump
//   i_mem_full           logger full flag; read data is valid only while high
//   i_data_log_from_mem  {bank_b, bank_a} word at o_addr_log_to_mem
//   o_addr_log_to_mem    read address to logger
//   o_byte/o_byte_valid  byte stream toward TX (registered)
//   i_byte_ready         stream ready from TX
//   o_busy               dump in progress
//   o_done               1-cycle pulse after the final byte is accepted
//   o_abort              1-cycle pulse when i_mem_full drops mid-dump
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start with full; address parked at 0
// HDR   | header bytes 0xA5, 0x5A on the stream (header build only)
// WAIT  | address stable, read-latency down-counter running
// SEND  | bytes of the captured word offered LSB first
// DONE  | one-cycle completion state, o_done high
module mem_log_reader #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int RD_LATENCY      = 1
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_start_read,
  input  logic                         i_mem_full,
  input  logic [2*BRAM_DATA_WIDTH-1:0] i_data_log_from_mem,
  output logic [BRAM_ADDR_WIDTH-1:0]   o_addr_log_to_mem,
  output logic [7:0]                   o_byte,
  output logic                         o_byte_valid,
  input  logic                         i_byte_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_abort
);

  localparam int WW     = 2 * BRAM_DATA_WIDTH;
  localparam int NBYTES = WW / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int LAT_W  = $clog2(RD_LATENCY + 1);

  localparam logic [IDX_W-1:0]           IDX_LAST  = IDX_W'(NBYTES - 1);
  localparam logic [LAT_W-1:0]           LAT_LOAD  = LAT_W'(RD_LATENCY);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_LAST = '1;

`ifdef MEM_LOG_READER_HEADER_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_WAIT, S_SEND, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SEND, S_DONE} state_t;
`endif

  state_t                       state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]                   byte_q, byte_d;
  logic                         valid_q, valid_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         abort_q, abort_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [IDX_W-1:0]             idx_inc;
  logic [LAT_W-1:0]             lat_q, lat_d;
  logic [WW-1:0]                word_q, word_d;
  logic                         hs;

  assign hs      = valid_q && i_byte_ready;
  assign idx_inc = idx_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      idx_q   <= '0;
      lat_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    idx_d   = idx_q;
    lat_d   = lat_q;
    word_d  = word_q;

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (i_start_read && i_mem_full) begin
          busy_d = 1'b1;
`ifdef MEM_LOG_READER_HEADER_EN
          state_d = S_HDR;
          valid_d = 1'b1;
          byte_d  = 8'hA5;
          idx_d   = '0;
`else
          state_d = S_WAIT;
          lat_d   = LAT_LOAD;
`endif
        end
      end
`ifdef MEM_LOG_READER_HEADER_EN
      S_HDR: begin
        if (hs) begin
          if (idx_q == '0) begin
            idx_d  = IDX_W'(1);
            byte_d = 8'h5A;
          end else begin
            idx_d   = '0;
            valid_d = 1'b0;
            lat_d   = LAT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
`endif
      S_WAIT: begin
        if (lat_q == '0) begin
          word_d  = i_data_log_from_mem;
          byte_d  = i_data_log_from_mem[7:0];
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = S_SEND;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_SEND: begin
        if (hs) begin
          if (idx_q != IDX_LAST) begin
            idx_d  = idx_inc;
            byte_d = word_q[{idx_inc, 3'b000} +: 8];
          end else if (addr_q != ADDR_LAST) begin
            addr_d  = addr_q + BRAM_ADDR_WIDTH'(1);
            valid_d = 1'b0;
            lat_d   = LAT_LOAD;
            state_d = S_WAIT;
          end else begin
            // Last byte of the last word: no address wrap, finish the dump.
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            addr_d  = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Losing the full flag invalidates read data; this overrides any
    // same-cycle handshake (that byte has already been accepted by TX).
    if (state_q != S_IDLE && state_q != S_DONE && !i_mem_full) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      addr_d  = '0;
      idx_d   = '0;
      lat_d   = '0;
    end
  end

  assign o_addr_log_to_mem = addr_q;
  assign o_byte            = byte_q;
  assign o_byte_valid      = valid_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_abort           = abort_q;

endmodule

// File: tb/tb_mem_log_reader.sv
module tb_mem_log_reader;

`ifdef MEM_LOG_READER_HEADER_EN
  localparam int HDR_N = 2;
`else
  localparam int HDR_N = 0;
`endif
  localparam int TOTAL = 32 + HDR_N;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start_read;
  logic        i_mem_full;
  logic [31:0] mem_q;
  logic [2:0]  o_addr_log_to_mem;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_abort;

  mem_log_reader #(
    .BRAM_ADDR_WIDTH(3),
    .BRAM_DATA_WIDTH(16),
    .RD_LATENCY     (1)
  ) dut (
    .clk                (clk),
    .i_rst              (i_rst),
    .i_start_read       (i_start_read),
    .i_mem_full         (i_mem_full),
    .i_data_log_from_mem(mem_q),
    .o_addr_log_to_mem  (o_addr_log_to_mem),
    .o_byte             (o_byte),
    .o_byte_valid       (o_byte_valid),
    .i_byte_ready       (i_byte_ready),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_abort            (o_abort)
  );

  always #5 clk = ~clk;

  // One-cycle read latency memory; every byte lane carries the address.
  always @(posedge clk) mem_q <= 32'hA0B0C0D0 + 32'h01010101 * {29'd0, o_addr_log_to_mem};

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int hs_cnt, done_cnt, abort_cnt, valid_cnt, busy_cnt;
  int stall_err, abort_valid_err, last_hs_cyc, done_cyc;
  logic [7:0] got[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  task automatic clear_mon();
    hs_cnt = 0; done_cnt = 0; abort_cnt = 0; valid_cnt = 0; busy_cnt = 0;
    stall_err = 0; abort_valid_err = 0; last_hs_cyc = -100; done_cyc = -1;
    got.delete();
  endtask

  // Negedge observer: inputs and registered outputs seen here are exactly
  // what the next rising edge will act on.
  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      cyc++;
      if (i_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !o_abort && !(o_byte_valid && o_byte == prev_byte)) stall_err++;
        if (o_byte_valid && i_byte_ready) begin
          got.push_back(o_byte);
          hs_cnt++;
          last_hs_cyc = cyc;
        end
        if (o_done) begin done_cnt++; done_cyc = cyc; end
        if (o_abort) begin abort_cnt++; if (o_byte_valid) abort_valid_err++; end
        if (o_byte_valid) valid_cnt++;
        if (o_busy) busy_cnt++;
        prev_stall = o_byte_valid && !i_byte_ready;
        prev_byte  = o_byte;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n);
    int m;
    if (n < HDR_N) return (n == 0) ? 8'hA5 : 8'h5A;
    m = n - HDR_N;
    return 8'hD0 - 8'((m % 4) * 16) + 8'(m / 4);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"},  {29'd0, o_addr_log_to_mem}, 32'd0);
    check({tag, "_byte"},  {24'd0, o_byte}, 32'd0);
    check({tag, "_valid"}, {31'd0, o_byte_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
    check({tag, "_done"},  {31'd0, o_done}, 32'd0);
    check({tag, "_abort"}, {31'd0, o_abort}, 32'd0);
  endtask

  typedef struct {
    int mode;         // 0: ready high, 1: random ready, 2: ready alternating
    int abort_after;  // drop full (and ready) after this many handshakes, 0 = never
    bit start_mid;    // extra start pulse while busy
    int exp_count;
    int exp_done;
    int exp_abort;
  } scen_t;

  scen_t tbl[5];

  task automatic run_scen(input int k, input scen_t s);
    bit finished = 1'b0;
    bit mid_sent = 1'b0;
    string t = $sformatf("s%0d", k);
    clear_mon();
    i_mem_full   = 1'b1;
    i_byte_ready = 1'b0;
    i_start_read = 1'b1;
    tick();
    i_start_read = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      case (s.mode)
        0:       i_byte_ready = 1'b1;
        1:       i_byte_ready = 1'($urandom_range(0, 1));
        default: i_byte_ready = c[0];
      endcase
      i_start_read = 1'b0;
      if (s.start_mid && !mid_sent && hs_cnt == 3) begin
        i_start_read = 1'b1;
        mid_sent = 1'b1;
      end
      if (s.abort_after != 0 && hs_cnt >= s.abort_after) begin
        i_mem_full   = 1'b0;
        i_byte_ready = 1'b0;
      end
      tick();
      if (done_cnt > 0 || abort_cnt > 0) begin
        finished = 1'b1;
        break;
      end
    end
    i_start_read = 1'b0;
    i_byte_ready = 1'b0;
    tick(); tick(); tick();
    i_mem_full = 1'b1;
    check({t, "_finished"}, {31'd0, finished}, 32'd1);
    check({t, "_bytes"}, hs_cnt, s.exp_count);
    check({t, "_done_pulses"}, done_cnt, s.exp_done);
    check({t, "_abort_pulses"}, abort_cnt, s.exp_abort);
    for (int n = 0; n < got.size() && n < s.exp_count; n++)
      check($sformatf("%s_byte%0d", t, n), {24'd0, got[n]}, {24'd0, exp_byte(n)});
    if (s.exp_done != 0) check({t, "_done_lat"}, done_cyc - last_hs_cyc, 1);
    check({t, "_busy_after"}, {31'd0, o_busy}, 32'd0);
    check({t, "_valid_after"}, {31'd0, o_byte_valid}, 32'd0);
    check({t, "_addr_after"}, {29'd0, o_addr_log_to_mem}, 32'd0);
    check({t, "_stall_stable"}, stall_err, 0);
    check({t, "_abort_valid"}, abort_valid_err, 0);
  endtask

  initial begin
    tbl[0] = '{mode: 0, abort_after: 0,  start_mid: 1'b0, exp_count: TOTAL, exp_done: 1, exp_abort: 0};
    tbl[1] = '{mode: 1, abort_after: 0,  start_mid: 1'b1, exp_count: TOTAL, exp_done: 1, exp_abort: 0};
    tbl[2] = '{mode: 0, abort_after: 10, start_mid: 1'b0, exp_count: 10,    exp_done: 0, exp_abort: 1};
    tbl[3] = '{mode: 2, abort_after: 0,  start_mid: 1'b0, exp_count: TOTAL, exp_done: 1, exp_abort: 0};
    tbl[4] = '{mode: 1, abort_after: 5,  start_mid: 1'b0, exp_count: 5,     exp_done: 0, exp_abort: 1};

    i_rst = 1'b1; i_start_read = 1'b0; i_mem_full = 1'b0; i_byte_ready = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    check_idle_outputs("reset");

    // Start without full is ignored entirely.
    clear_mon();
    i_start_read = 1'b1;
    tick();
    i_start_read = 1'b0;
    for (int c = 0; c < 50; c++) tick();
    check("nofull_valid", valid_cnt, 0);
    check("nofull_busy",  busy_cnt, 0);
    check("nofull_done",  done_cnt, 0);
    check("nofull_abort", abort_cnt, 0);

    for (int k = 0; k < 5; k++) run_scen(k, tbl[k]);

    // Reset pulse in the middle of a word.
    clear_mon();
    i_mem_full = 1'b1; i_byte_ready = 1'b1; i_start_read = 1'b1;
    tick();
    i_start_read = 1'b0;
    for (int c = 0; c < 500 && hs_cnt < 6; c++) tick();
    check("rst_mid_reached", hs_cnt, 6);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_idle_outputs("rst_mid");
    i_byte_ready = 1'b0;
    tick(); tick();
    check("rst_mid_bytes", hs_cnt, 6);

    // Full drops in the same cycle as an accepted byte: byte counts, then abort.
    clear_mon();
    i_mem_full = 1'b1; i_byte_ready = 1'b1; i_start_read = 1'b1;
    tick();
    i_start_read = 1'b0;
    for (int c = 0; c < 500 && hs_cnt < 5; c++) tick();
    check("abort_hs_reached", hs_cnt, 5);
    i_mem_full = 1'b0;
    tick(); tick(); tick();
    check("abort_hs_bytes", hs_cnt, 6);
    check("abort_hs_pulses", abort_cnt, 1);
    check("abort_hs_valid", {31'd0, o_byte_valid}, 32'd0);
    check("abort_hs_busy", {31'd0, o_busy}, 32'd0);
    i_mem_full = 1'b1; i_byte_ready = 1'b0;
    tick();

    // After every abort/reset, a fresh dump still starts from address 0.
    run_scen(5, tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
